mips_hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and operand-forwarding unit for the pipelined MIPS core. It tracks every register write in flight between issue (ID) and register-file commit in a DEPTH-entry shift scoreboard. Each cycle it selects, for both ID source operands, either the register-file value or the youngest in-flight result. When that result is not yet produced, it stalls ID and injects a bubble. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/mips_hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_mips_hazard_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_scoreboard.sv
// Hazard detection and operand forwarding for the pipelined MIPS core.
// A DEPTH-entry shift scoreboard tracks in-flight register writes from EX to RF commit.
module mips_hazard_scoreboard #(
   parameter int REG_ID_W = 5,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int LAT_W    = $clog2(DEPTH + 1),
   parameter int CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [REG_ID_W-1:0]     id_rs,
   input  logic [REG_ID_W-1:0]     id_rt,
   input  logic                    id_rs_used,
   input  logic                    id_rt_used,
   input  logic                    id_we,
   input  logic [REG_ID_W-1:0]     id_rd,
   input  logic [LAT_W-1:0]        id_lat,
   input  logic                    flush,
   input  logic [DATA_W-1:0]       rf_rs_data,
   input  logic [DATA_W-1:0]       rf_rt_data,
   input  logic [DEPTH*DATA_W-1:0] stage_data,
   output logic                    stall,
   output logic                    issue,
   output logic [DATA_W-1:0]       rs_data,
   output logic [DATA_W-1:0]       rt_data,
   output logic [LAT_W-1:0]        rs_src,
   output logic [LAT_W-1:0]        rt_src,
   output logic [LAT_W-1:0]        inflight,
   output logic [CNT_W-1:0]        stall_count
);

   logic [DEPTH:1]      sb_valid;
   logic [DEPTH:1]      sb_we;
   logic [REG_ID_W-1:0] sb_rd  [1:DEPTH];
   logic [LAT_W-1:0]    sb_lat [1:DEPTH];

   logic                rs_found, rt_found;
   logic                rs_blocked, rt_blocked;
   logic [LAT_W-1:0]    lat_clamped;
   logic [LAT_W-1:0]    inflight_next;

   // Scan from the youngest stage; the first match decides forward-or-block.
   always_comb begin
      rs_src     = '0;
      rt_src     = '0;
      rs_data    = rf_rs_data;
      rt_data    = rf_rt_data;
      rs_found   = 1'b0;
      rt_found   = 1'b0;
      rs_blocked = 1'b0;
      rt_blocked = 1'b0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         if (!rs_found && id_rs_used && (id_rs != '0) && sb_valid[k] && sb_we[k]
             && (sb_rd[k] == id_rs)) begin
            rs_found = 1'b1;
            if (LAT_W'(k) >= sb_lat[k]) begin
               rs_src  = LAT_W'(k);
               rs_data = stage_data[(k-1)*DATA_W +: DATA_W];
            end else begin
               rs_blocked = 1'b1;
            end
         end
         if (!rt_found && id_rt_used && (id_rt != '0) && sb_valid[k] && sb_we[k]
             && (sb_rd[k] == id_rt)) begin
            rt_found = 1'b1;
            if (LAT_W'(k) >= sb_lat[k]) begin
               rt_src  = LAT_W'(k);
               rt_data = stage_data[(k-1)*DATA_W +: DATA_W];
            end else begin
               rt_blocked = 1'b1;
            end
         end
      end
   end

   assign stall = id_valid && !flush && (rs_blocked || rt_blocked);
   assign issue = id_valid && !flush && !stall;

   always_comb begin
      lat_clamped = id_lat;
      if (id_lat == '0)
         lat_clamped = LAT_W'(1);
      else if (id_lat > LAT_W'(DEPTH))
         lat_clamped = LAT_W'(DEPTH);
   end

   // Count of writers that will occupy stages 1..DEPTH after this edge.
   always_comb begin
      inflight_next = (issue && id_we) ? LAT_W'(1) : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         if (sb_valid[k] && sb_we[k])
            inflight_next = inflight_next + LAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_valid    <= '0;
         sb_we       <= '0;
         inflight    <= '0;
         stall_count <= '0;
         for (int unsigned k = 1; k <= DEPTH; k++) begin
            sb_rd[k]  <= '0;
            sb_lat[k] <= '0;
         end
      end else begin
         for (int unsigned k = 2; k <= DEPTH; k++) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_we[k]    <= sb_we[k-1];
            sb_rd[k]    <= sb_rd[k-1];
            sb_lat[k]   <= sb_lat[k-1];
         end
         sb_valid[1] <= issue;
         sb_we[1]    <= id_we;
         sb_rd[1]    <= id_rd;
         sb_lat[1]   <= lat_clamped;
         inflight    <= inflight_next;
         if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Self-checking bench for mips_hazard_scoreboard: directed scenarios plus random traffic
// against an age-based model of issued instructions.
module tb_mips_hazard_scoreboard;

   localparam int REG_ID_W = 5;
   localparam int DATA_W   = 32;
   localparam int DEPTH    = 4;
   localparam int LAT_W    = $clog2(DEPTH + 1);
   localparam int CNT_W    = 32;

   logic                    clk;
   logic                    rst;
   logic                    id_valid;
   logic [REG_ID_W-1:0]     id_rs, id_rt, id_rd;
   logic                    id_rs_used, id_rt_used, id_we;
   logic [LAT_W-1:0]        id_lat;
   logic                    flush;
   logic [DATA_W-1:0]       rf_rs_data, rf_rt_data;
   logic [DEPTH*DATA_W-1:0] stage_data;
   logic                    stall, issue;
   logic [DATA_W-1:0]       rs_data, rt_data;
   logic [LAT_W-1:0]        rs_src, rt_src, inflight;
   logic [CNT_W-1:0]        stall_count;

   mips_hazard_scoreboard #(
      .REG_ID_W(REG_ID_W),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .LAT_W   (LAT_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .id_we      (id_we),
      .id_rd      (id_rd),
      .id_lat     (id_lat),
      .flush      (flush),
      .rf_rs_data (rf_rs_data),
      .rf_rt_data (rf_rt_data),
      .stage_data (stage_data),
      .stall      (stall),
      .issue      (issue),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .rs_src     (rs_src),
      .rt_src     (rt_src),
      .inflight   (inflight),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: every issued instruction remembered with its issue cycle; its stage is its age.
   typedef struct {
      int       t;
      bit       we;
      int       rd;
      int       lat;
   } rec_t;

   rec_t q[$];
   int   cyc;
   int   exp_cnt;
   bit   e_stall, e_issue;
   int   n_tests, n_fail;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp_lat(input int l);
      if (l == 0) return 1;
      if (l > DEPTH) return DEPTH;
      return l;
   endfunction

   task automatic resolve(input int s, input bit used, input logic [DATA_W-1:0] rf,
                          output int src, output logic [DATA_W-1:0] data, output bit blk);
      int best, best_lat, age;
      best = 0; best_lat = 0;
      src = 0; data = rf; blk = 0;
      if (used && s != 0) begin
         foreach (q[i]) begin
            age = cyc - q[i].t;
            if (age >= 1 && age <= DEPTH && q[i].we && q[i].rd == s && (best == 0 || age < best)) begin
               best = age;
               best_lat = q[i].lat;
            end
         end
      end
      if (best != 0) begin
         if (best >= best_lat) begin
            src  = best;
            data = stage_data[(best-1)*DATA_W +: DATA_W];
         end else begin
            blk = 1;
         end
      end
   endtask

   task automatic eval_and_check();
      int               rs_s, rt_s, infl, age;
      logic [DATA_W-1:0] rs_d, rt_d;
      bit               rs_b, rt_b;
      resolve(int'(id_rs), id_rs_used, rf_rs_data, rs_s, rs_d, rs_b);
      resolve(int'(id_rt), id_rt_used, rf_rt_data, rt_s, rt_d, rt_b);
      e_stall = id_valid && !flush && (rs_b || rt_b);
      e_issue = id_valid && !flush && !e_stall;
      infl = 0;
      foreach (q[i]) begin
         age = cyc - q[i].t;
         if (age >= 1 && age <= DEPTH && q[i].we) infl++;
      end
      check("stall",       64'(stall),       64'(e_stall));
      check("issue",       64'(issue),       64'(e_issue));
      check("rs_src",      64'(rs_src),      64'(rs_s));
      check("rt_src",      64'(rt_src),      64'(rt_s));
      check("rs_data",     64'(rs_data),     64'(rs_d));
      check("rt_data",     64'(rt_data),     64'(rt_d));
      check("inflight",    64'(inflight),    64'(infl));
      check("stall_count", 64'(stall_count), 64'(exp_cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      if (e_issue) q.push_back('{cyc, id_we, int'(id_rd), clamp_lat(int'(id_lat))});
      if (e_stall) exp_cnt++;
      cyc++;
      while (q.size() > 0 && (cyc - q[0].t) > DEPTH) void'(q.pop_front());
   endtask

   task automatic set_rf();
      rf_rs_data = (id_rs == '0) ? '0 : {27'h5555_AAA, id_rs};
      rf_rt_data = (id_rt == '0) ? '0 : {27'h2AAA_555, id_rt};
   endtask

   task automatic apply(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input bit we, input int rd, input int lat, input bit fl);
      @(negedge clk);
      id_valid   = v;
      id_rs      = REG_ID_W'(rs);
      id_rs_used = rsu;
      id_rt      = REG_ID_W'(rt);
      id_rt_used = rtu;
      id_we      = we;
      id_rd      = REG_ID_W'(rd);
      id_lat     = LAT_W'(lat);
      flush      = fl;
      set_rf();
      #1 eval_and_check();
   endtask

   task automatic idle();
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   int cnt_before;

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; exp_cnt = 0;
      rst = 1'b0;
      id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
      id_we = 0; id_rd = '0; id_lat = '0; flush = 0;
      rf_rs_data = '0; rf_rt_data = '0;
      stage_data = {32'h4444_0004, 32'h3333_0003, 32'hDEAD_BEEF, 32'h0000_0010};

      // Reset state
      @(posedge clk);
      idle();
      @(negedge clk);
      rst = 1'b1;

      // ALU chain
      apply(1, 1, 1, 2, 1, 1, 3, 1, 0); tick();
      apply(1, 3, 1, 3, 1, 1, 4, 1, 0);
      check("alu_stall", 64'(stall), 64'd0);
      check("alu_rs_src", 64'(rs_src), 64'd1);
      check("alu_rt_src", 64'(rt_src), 64'd1);
      check("alu_rs_data", 64'(rs_data), 64'h10);
      tick();

      // Load-use
      apply(1, 1, 1, 0, 0, 1, 5, 2, 0); tick();
      cnt_before = int'(stall_count);
      apply(1, 5, 1, 0, 1, 1, 6, 1, 0);
      check("lu_stall", 64'(stall), 64'd1);
      check("lu_issue", 64'(issue), 64'd0);
      tick();
      apply(1, 5, 1, 0, 1, 1, 6, 1, 0);
      check("lu_cnt", 64'(stall_count), 64'(cnt_before + 1));
      check("lu_stall2", 64'(stall), 64'd0);
      check("lu_rs_src", 64'(rs_src), 64'd2);
      check("lu_rs_data", 64'(rs_data), 64'hDEAD_BEEF);
      tick();

      // Youngest wins
      apply(1, 0, 0, 0, 0, 1, 7, 1, 0); tick();
      apply(1, 0, 0, 0, 0, 1, 7, 1, 0); tick();
      apply(1, 7, 1, 0, 0, 0, 0, 1, 0);
      check("young_rs_src", 64'(rs_src), 64'd1);
      tick();

      // $0 and unused operand
      apply(1, 0, 0, 0, 0, 1, 0, 2, 0); tick();
      apply(1, 0, 1, 0, 1, 0, 0, 1, 0);
      check("r0_rs_src", 64'(rs_src), 64'd0);
      check("r0_stall", 64'(stall), 64'd0);
      tick();
      apply(1, 1, 1, 0, 0, 1, 9, 2, 0); tick();
      apply(1, 1, 1, 9, 0, 0, 0, 1, 0);
      check("unused_stall", 64'(stall), 64'd0);
      tick();

      // Flush with pending hazard
      apply(1, 1, 1, 0, 0, 1, 8, 2, 0); tick();
      cnt_before = int'(stall_count);
      apply(1, 8, 1, 0, 0, 1, 10, 1, 1);
      check("fl_stall", 64'(stall), 64'd0);
      check("fl_issue", 64'(issue), 64'd0);
      tick();
      apply(1, 10, 1, 0, 0, 0, 0, 1, 0);
      check("fl_cnt", 64'(stall_count), 64'(cnt_before));
      check("fl_bubble", 64'(rs_src), 64'd0);
      tick();

      // DEPTH boundary
      apply(1, 0, 0, 0, 0, 1, 11, 1, 0); tick();
      idle(); tick();
      idle(); tick();
      idle(); tick();
      apply(1, 11, 1, 0, 0, 0, 0, 1, 0);
      check("edge_src4", 64'(rs_src), 64'(DEPTH));
      check("edge_data4", 64'(rs_data), 64'h4444_0004);
      tick();
      apply(1, 11, 1, 0, 0, 0, 0, 1, 0);
      check("edge_src0", 64'(rs_src), 64'd0);
      tick();

      // Reset mid-stall
      apply(1, 1, 1, 0, 0, 1, 12, 4, 0); tick();
      apply(1, 12, 1, 0, 0, 0, 0, 1, 0);
      check("rst_pre_stall", 64'(stall), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_count", 64'(stall_count), 64'd0);
      check("rst_rs_src", 64'(rs_src), 64'd0);
      check("rst_rs_data", 64'(rs_data), 64'(rf_rs_data));
      id_valid = 0;
      q.delete();
      exp_cnt = 0;
      e_issue = 0; e_stall = 0;
      @(negedge clk);
      rst = 1'b1;

      // Random traffic; a stalled instruction is held in ID as the pipeline would.
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         for (int k = 0; k < DEPTH; k++) stage_data[k*DATA_W +: DATA_W] = $urandom;
         if (!e_stall) begin
            id_valid   = ($urandom_range(9, 0) != 0);
            id_rs      = REG_ID_W'($urandom_range(7, 0));
            id_rt      = REG_ID_W'($urandom_range(7, 0));
            id_rs_used = ($urandom_range(3, 0) != 0);
            id_rt_used = ($urandom_range(1, 0) != 0);
            id_we      = ($urandom_range(3, 0) != 0);
            id_rd      = REG_ID_W'($urandom_range(7, 0));
            id_lat     = LAT_W'($urandom_range(7, 0));
         end
         flush = ($urandom_range(9, 0) == 0);
         set_rf();
         #1 eval_and_check();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
